// File: rtl/avalon_mm_test_master_if.sv
// Command/response stream plus Avalon-MM master bus bundle for avalon_mm_test_master.
// master modport is the DUT view; slave modport is the host/bus-model view.
// Optional AVM_WAITREQ_EN adds master_waitrequest.
interface avalon_mm_test_master_if #(
   parameter int WIDTH = 32
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_write;
   logic [3:0]       cmd_address;
   logic [WIDTH-1:0] cmd_writedata;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_readdata;
   logic [3:0]       master_address;
   logic             master_read;
   logic             master_write;
   logic [WIDTH-1:0] master_writedata;
   logic [WIDTH-1:0] master_readdata;
`ifdef AVM_WAITREQ_EN
   logic             master_waitrequest;

   modport master (
      input  cmd_valid, cmd_write, cmd_address, cmd_writedata, rsp_ready,
             master_readdata, master_waitrequest,
      output cmd_ready, rsp_valid, rsp_readdata,
             master_address, master_read, master_write, master_writedata
   );
   modport slave (
      output cmd_valid, cmd_write, cmd_address, cmd_writedata, rsp_ready,
             master_readdata, master_waitrequest,
      input  cmd_ready, rsp_valid, rsp_readdata,
             master_address, master_read, master_write, master_writedata
   );
`else
   modport master (
      input  cmd_valid, cmd_write, cmd_address, cmd_writedata, rsp_ready,
             master_readdata,
      output cmd_ready, rsp_valid, rsp_readdata,
             master_address, master_read, master_write, master_writedata
   );
   modport slave (
      output cmd_valid, cmd_write, cmd_address, cmd_writedata, rsp_ready,
             master_readdata,
      input  cmd_ready, rsp_valid, rsp_readdata,
             master_address, master_read, master_write, master_writedata
   );
`endif
endinterface

// File: rtl/avalon_mm_test_master.sv
// Avalon-MM master: buffers read/write commands in a FIFO, issues them one at a time, returns read data.
// Latency: 1 idle cycle from push into empty FIFO to strobe; read data captured READ_LATENCY cycles after the strobe.
// Backpressure: registered cmd_ready = !full; bus issue stalls while a read response waits for rsp_ready.
// Optional feature macro: AVM_WAITREQ_EN (adds master_waitrequest bus stall).
module avalon_mm_test_master #(
   parameter int WIDTH        = 32,
   parameter int FIFO_DEPTH   = 4,
   parameter int READ_LATENCY = 1
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   avalon_mm_test_master_if.master bus_if,
   output logic                    busy_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(READ_LATENCY + 1);

   typedef struct packed {
      logic             write;
      logic [3:0]       addr;
      logic [WIDTH-1:0] data;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, BUS, RDWAIT, RESP} state_t;

   // ---------------- command FIFO ----------------
   cmd_t          mem_q [FIFO_DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          cmd_ready_q;
   logic          full_d;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   cmd_t          cmd_in;
   cmd_t          head;

   assign cmd_in     = {bus_if.cmd_write, bus_if.cmd_address, bus_if.cmd_writedata};
   assign push       = bus_if.cmd_valid && cmd_ready_q;
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign head       = mem_q[rd_ptr_q[AW-1:0]];

   // Next pointers and next-cycle full flag; cmd_ready is registered from this.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
   end

   // FIFO pointer and ready registers; reset empties the queue.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cmd_ready_q <= 1'b1;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cmd_ready_q <= !full_d;
      end
   end

   // FIFO storage; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= cmd_in;
   end

   // ---------------- bus FSM ----------------
   state_t           state_q, state_d;
   logic [3:0]       addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic             read_q, read_d;
   logic             write_q, write_d;
   logic [LW-1:0]    lat_q, lat_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             bus_stall;

`ifdef AVM_WAITREQ_EN
   assign bus_stall = bus_if.master_waitrequest;
`else
   assign bus_stall = 1'b0;
`endif

   // Next state, FIFO pop and bus register loads; strobes default low so each lasts one cycle.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      read_d  = 1'b0;
      write_d = 1'b0;
      lat_d   = lat_q;
      rdata_d = rdata_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               addr_d  = head.addr;
               // Read commands leave the last write data on the bus untouched.
               wdata_d = head.write ? head.data : wdata_q;
               write_d = head.write;
               read_d  = !head.write;
               state_d = BUS;
            end
         end
         BUS: begin
            if (bus_stall) begin
               read_d  = read_q;
               write_d = write_q;
            end else if (write_q) begin
               // Chain the next command straight onto the bus for back-to-back issue.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  addr_d  = head.addr;
                  wdata_d = head.write ? head.data : wdata_q;
                  write_d = head.write;
                  read_d  = !head.write;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               lat_d   = LW'(READ_LATENCY);
               state_d = RDWAIT;
            end
         end
         RDWAIT: begin
            if (lat_q == LW'(1)) begin
               rdata_d = bus_if.master_readdata;
               state_d = RESP;
            end else begin
               lat_d = lat_q - LW'(1);
            end
         end
         RESP: begin
            if (bus_if.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM and bus/response registers; reset abandons any transaction in flight.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         lat_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         read_q  <= read_d;
         write_q <= write_d;
         lat_q   <= lat_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus_if.cmd_ready        = cmd_ready_q;
   assign bus_if.master_address   = addr_q;
   assign bus_if.master_writedata = wdata_q;
   assign bus_if.master_read      = read_q;
   assign bus_if.master_write     = write_q;
   assign bus_if.rsp_valid        = (state_q == RESP);
   assign bus_if.rsp_readdata     = rdata_q;
   assign busy_o                  = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_avalon_mm_test_master.sv
// Directed self-checking bench for avalon_mm_test_master (WIDTH=32, FIFO_DEPTH=4, READ_LATENCY=1).
// A small slave model returns slave_rdata one cycle after each read strobe.
// Bus strobes and accepted responses are logged at the falling edge.
module tb_avalon_mm_test_master;
   typedef logic [36:0] ent_t;  // {is_write, address, data}

   logic clk = 1'b0;
   logic rst;
   logic busy;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   both_cnt = 0;
   logic rd_pend = 1'b0;
   logic [31:0] slave_rdata = 32'h0;
   ent_t        log_q[$];
   int          log_cyc[$];
   logic [31:0] rsp_q[$];

   avalon_mm_test_master_if #(.WIDTH(32)) bus_if ();

   avalon_mm_test_master #(.WIDTH(32), .FIFO_DEPTH(4), .READ_LATENCY(1)) dut (
      .clk_i  (clk),
      .reset_i(rst),
      .bus_if (bus_if),
      .busy_o (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Slave model: read data valid exactly one cycle after the read strobe, garbage otherwise.
   always @(posedge clk) begin
      #1;
      bus_if.master_readdata = rd_pend ? slave_rdata : 32'hBAD0_BAD0;
   end

   // Bus/response monitor.
   always @(negedge clk) begin
      rd_pend = (bus_if.master_read === 1'b1);
      if (bus_if.master_read === 1'b1 && bus_if.master_write === 1'b1) both_cnt++;
      if (bus_if.master_write === 1'b1) begin
         log_q.push_back({1'b1, bus_if.master_address, bus_if.master_writedata});
         log_cyc.push_back(cyc);
      end
      if (bus_if.master_read === 1'b1) begin
         log_q.push_back({1'b0, bus_if.master_address, 32'h0});
         log_cyc.push_back(cyc);
      end
      if (bus_if.rsp_valid === 1'b1 && bus_if.rsp_ready === 1'b1) rsp_q.push_back(bus_if.rsp_readdata);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      log_q.delete();
      log_cyc.delete();
      rsp_q.delete();
   endtask

   task automatic push_cmd(input logic w, input logic [3:0] a, input logic [31:0] d);
      int n = 0;
      bus_if.cmd_write     = w;
      bus_if.cmd_address   = a;
      bus_if.cmd_writedata = d;
      bus_if.cmd_valid     = 1'b1;
      while (bus_if.cmd_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL push_timeout: cmd_ready=%b after %0d cycles, required 1", bus_if.cmd_ready, n);
      end
      tick();
      bus_if.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string name);
      int n = 0;
      while (bus_if.rsp_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) begin
         checks++; errors++;
         $display("FAIL %s: rsp_valid=%b after %0d cycles, required 1", name, bus_if.rsp_valid, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if ({bus_if.master_read, bus_if.master_write, bus_if.master_address, bus_if.master_writedata} !== 38'h0) begin
         errors++;
         $display("FAIL reset_bus: rd=%b wr=%b addr=%h wdata=%h, required all 0",
                  bus_if.master_read, bus_if.master_write, bus_if.master_address, bus_if.master_writedata);
      end
      checks++;
      if ({bus_if.rsp_valid, bus_if.rsp_readdata, busy} !== 34'h0) begin
         errors++;
         $display("FAIL reset_rsp: rsp_valid=%b rsp_readdata=%h busy=%b, required 0", bus_if.rsp_valid, bus_if.rsp_readdata, busy);
      end
      checks++;
      if (bus_if.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_cmd_ready: got %b, required 1", bus_if.cmd_ready);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || bus_if.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_idle: busy=%b cmd_ready=%b, required 0/1", busy, bus_if.cmd_ready);
      end
   endtask

   task automatic test_single_write();
      clear_logs();
      push_cmd(1'b1, 4'h0, 32'h0000_0001);
      checks++;
      if (bus_if.master_write !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL sw_issue_gap: write=%b busy=%b, required 0/1", bus_if.master_write, busy);
      end
      tick();
      checks++;
      if ({bus_if.master_write, bus_if.master_read, bus_if.master_address, bus_if.master_writedata} !== {1'b1, 1'b0, 4'h0, 32'h1}) begin
         errors++;
         $display("FAIL sw_strobe: wr=%b rd=%b addr=%h wdata=%h, required 1/0/0/00000001",
                  bus_if.master_write, bus_if.master_read, bus_if.master_address, bus_if.master_writedata);
      end
      tick();
      checks++;
      if (bus_if.master_write !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL sw_done: write=%b busy=%b, required 0/0", bus_if.master_write, busy);
      end
      checks++;
      if (bus_if.master_writedata !== 32'h1 || bus_if.master_address !== 4'h0) begin
         errors++;
         $display("FAIL sw_hold: addr=%h wdata=%h, required 0/00000001", bus_if.master_address, bus_if.master_writedata);
      end
      tick(); tick();
      checks++;
      if (log_q.size() !== 1) begin
         errors++;
         $display("FAIL sw_count: %0d strobe cycles, required 1", log_q.size());
      end
   endtask

   task automatic test_back_to_back();
      ent_t e0, e1;
      e0 = {1'b1, 4'h0, 32'h0000_00A5};
      e1 = {1'b1, 4'h4, 32'h0000_005A};
      clear_logs();
      push_cmd(1'b1, 4'h0, 32'h0000_00A5);
      push_cmd(1'b1, 4'h4, 32'h0000_005A);
      for (int i = 0; i < 6; i++) tick();
      checks++;
      if (log_q.size() !== 2) begin
         errors++;
         $display("FAIL b2b_count: %0d strobes, required 2", log_q.size());
      end else begin
         checks++;
         if (log_q[0] !== e0 || log_q[1] !== e1) begin
            errors++;
            $display("FAIL b2b_order: got %h %h, required %h %h", log_q[0], log_q[1], e0, e1);
         end
         checks++;
         if (log_cyc[1] !== log_cyc[0] + 1) begin
            errors++;
            $display("FAIL b2b_gap: strobes at cycles %0d and %0d, required consecutive", log_cyc[0], log_cyc[1]);
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_read_stall();
      int n = 0;
      int bad = 0;
      clear_logs();
      bus_if.rsp_ready = 1'b0;
      slave_rdata = 32'h1234_5678;
      push_cmd(1'b0, 4'h8, 32'h0);
      while (bus_if.rsp_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n !== 3) begin
         errors++;
         $display("FAIL rd_latency: rsp_valid after %0d cycles, required 3", n);
      end
      checks++;
      if (bus_if.rsp_readdata !== 32'h1234_5678) begin
         errors++;
         $display("FAIL rd_data: got %h, required 12345678", bus_if.rsp_readdata);
      end
      slave_rdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_readdata !== 32'h1234_5678 ||
             bus_if.master_read !== 1'b0 || bus_if.master_write !== 1'b0) begin
            errors++; bad++;
            $display("FAIL rd_hold: cycle %0d valid=%b data=%h rd=%b wr=%b, required 1/12345678/0/0",
                     i, bus_if.rsp_valid, bus_if.rsp_readdata, bus_if.master_read, bus_if.master_write);
         end
      end
      bus_if.rsp_ready = 1'b1;
      tick();
      bus_if.rsp_ready = 1'b0;
      checks++;
      if (bus_if.rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rd_accept: valid=%b busy=%b, required 0/0", bus_if.rsp_valid, busy);
      end
      checks++;
      if (log_q.size() !== 1 || rsp_q.size() !== 1) begin
         errors++;
         $display("FAIL rd_once: %0d bus cycles %0d responses, required 1/1", log_q.size(), rsp_q.size());
      end
   endtask

   task automatic test_fifo_full();
      logic        cw [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [3:0]  ca [6] = '{4'h0, 4'h4, 4'h8, 4'h0, 4'h4, 4'h0};
      logic [31:0] cd [6] = '{32'h11, 32'h22, 32'h0, 32'h33, 32'h44, 32'h55};
      ent_t        ex [7];
      int          n = 0;
      clear_logs();
      bus_if.rsp_ready = 1'b0;
      slave_rdata = 32'hCAFE_0001;
      push_cmd(1'b0, 4'h8, 32'h0);
      wait_rsp("full_first_rsp");
      slave_rdata = 32'hBEEF_0002;
      for (int i = 0; i < 6; i++) begin
         bus_if.cmd_write     = cw[i];
         bus_if.cmd_address   = ca[i];
         bus_if.cmd_writedata = cd[i];
         bus_if.cmd_valid     = 1'b1;
         checks++;
         if (bus_if.cmd_ready !== (i < 4)) begin
            errors++;
            $display("FAIL full_ready: attempt %0d cmd_ready=%b, required %0d", i, bus_if.cmd_ready, (i < 4));
         end
         tick();
      end
      bus_if.cmd_valid = 1'b0;
      checks++;
      if (log_q.size() !== 1 || bus_if.rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL full_no_issue: %0d bus cycles rsp_valid=%b, required 1/1", log_q.size(), bus_if.rsp_valid);
      end
      bus_if.rsp_ready = 1'b1;
      push_cmd(cw[4], ca[4], cd[4]);
      push_cmd(cw[5], ca[5], cd[5]);
      while (busy !== 1'b0 && n < 40) begin
         tick();
         n++;
      end
      bus_if.rsp_ready = 1'b0;
      checks++;
      if (n >= 40) begin
         errors++;
         $display("FAIL full_drain_timeout: busy=%b after %0d cycles, required 0", busy, n);
      end
      ex[0] = {1'b0, 4'h8, 32'h0};
      for (int i = 0; i < 6; i++) ex[i+1] = {cw[i], ca[i], cw[i] ? cd[i] : 32'h0};
      checks++;
      if (log_q.size() !== 7) begin
         errors++;
         $display("FAIL full_drain_count: %0d bus cycles, required 7", log_q.size());
      end else begin
         for (int i = 0; i < 7; i++) begin
            checks++;
            if (log_q[i] !== ex[i]) begin
               errors++;
               $display("FAIL full_drain_order: entry %0d got %h, required %h", i, log_q[i], ex[i]);
            end
         end
      end
      checks++;
      if (rsp_q.size() !== 2) begin
         errors++;
         $display("FAIL full_rsp_count: %0d responses, required 2", rsp_q.size());
      end else begin
         checks++;
         if (rsp_q[0] !== 32'hCAFE_0001 || rsp_q[1] !== 32'hBEEF_0002) begin
            errors++;
            $display("FAIL full_rsp_data: got %h %h, required cafe0001 beef0002", rsp_q[0], rsp_q[1]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      bus_if.rsp_ready = 1'b0;
      slave_rdata = 32'h1111_1111;
      push_cmd(1'b0, 4'h8, 32'h0);
      wait_rsp("mid_first_rsp");
      push_cmd(1'b0, 4'h8, 32'h0);
      push_cmd(1'b1, 4'h0, 32'h1);
      push_cmd(1'b1, 4'h4, 32'h2);
      push_cmd(1'b1, 4'h0, 32'h3);
      bus_if.rsp_ready = 1'b1;
      tick();
      bus_if.rsp_ready = 1'b0;
      tick();
      checks++;
      if (bus_if.master_read !== 1'b1) begin
         errors++;
         $display("FAIL mid_read_issue: read=%b, required 1", bus_if.master_read);
      end
      tick();
      checks++;
      if (bus_if.master_read !== 1'b0 || busy !== 1'b1 || bus_if.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_rdwait: read=%b busy=%b rsp_valid=%b, required 0/1/0", bus_if.master_read, busy, bus_if.rsp_valid);
      end
      rst = 1'b1;
      #1;
      clear_logs();
      checks++;
      if ({bus_if.master_read, bus_if.master_write, bus_if.master_address, bus_if.master_writedata,
           bus_if.rsp_valid, bus_if.rsp_readdata, busy} !== 72'h0) begin
         errors++;
         $display("FAIL mid_reset_outputs: rd=%b wr=%b addr=%h wdata=%h rv=%b rdata=%h busy=%b, required all 0",
                  bus_if.master_read, bus_if.master_write, bus_if.master_address, bus_if.master_writedata,
                  bus_if.rsp_valid, bus_if.rsp_readdata, busy);
      end
      checks++;
      if (bus_if.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_ready: cmd_ready=%b, required 1", bus_if.cmd_ready);
      end
      tick(); tick();
      rst = 1'b0;
      bus_if.rsp_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (busy !== 1'b0 || bus_if.rsp_valid !== 1'b0) bad++;
      end
      bus_if.rsp_ready = 1'b0;
      checks++;
      if (bad !== 0 || log_q.size() !== 0 || rsp_q.size() !== 0) begin
         errors++;
         $display("FAIL mid_abandon: busy/valid cycles=%0d bus cycles=%0d responses=%0d, required 0/0/0",
                  bad, log_q.size(), rsp_q.size());
      end
   endtask

`ifdef AVM_WAITREQ_EN
   task automatic test_waitreq();
      bus_if.master_waitrequest = 1'b1;
      push_cmd(1'b1, 4'h4, 32'h7);
      push_cmd(1'b1, 4'h0, 32'h9);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) bus_if.master_waitrequest = 1'b0;
         checks++;
         if ({bus_if.master_write, bus_if.master_address, bus_if.master_writedata} !== {1'b1, 4'h4, 32'h7}) begin
            errors++;
            $display("FAIL wreq_hold: cycle %0d wr=%b addr=%h wdata=%h, required 1/4/00000007",
                     i, bus_if.master_write, bus_if.master_address, bus_if.master_writedata);
         end
         tick();
      end
      checks++;
      if ({bus_if.master_write, bus_if.master_address, bus_if.master_writedata} !== {1'b1, 4'h0, 32'h9}) begin
         errors++;
         $display("FAIL wreq_next: wr=%b addr=%h wdata=%h, required 1/0/00000009",
                  bus_if.master_write, bus_if.master_address, bus_if.master_writedata);
      end
      tick();
      checks++;
      if (bus_if.master_write !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL wreq_done: wr=%b busy=%b, required 0/0", bus_if.master_write, busy);
      end
   endtask
`endif

   task automatic test_exclusive();
      checks++;
      if (both_cnt !== 0) begin
         errors++;
         $display("FAIL strobe_exclusive: read and write together in %0d cycles, required 0", both_cnt);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus_if.cmd_valid     = 1'b0;
      bus_if.cmd_write     = 1'b0;
      bus_if.cmd_address   = 4'h0;
      bus_if.cmd_writedata = 32'h0;
      bus_if.rsp_ready     = 1'b0;
`ifdef AVM_WAITREQ_EN
      bus_if.master_waitrequest = 1'b0;
`endif
      test_reset();
      test_single_write();
      test_back_to_back();
      test_read_stall();
      test_fifo_full();
      test_reset_mid();
`ifdef AVM_WAITREQ_EN
      test_waitreq();
`endif
      test_exclusive();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within 200000 time units");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/avalon_mm_test_master.md
Name: avalon_mm_test_master

Overview:
- Avalon-MM master that drives the arithmetic testbench's register slave (operand A at 0x0, operand B at 0x4, result O at 0x8) from a simple command/response stream.
- Commands are buffered in a small FIFO and issued one at a time on the bus.
- Read results are returned on a valid/ready response port.
- Lets a host-side sequencer or bench program operands and poll results without knowing bus timing.

Parameters:
- WIDTH, 32, data width of commands, responses and the bus.
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- READ_LATENCY, 1, fixed cycles from the read-asserted cycle to the cycle in which master_readdata is valid; at least 1.

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_address  in  4  target register address
- cmd_writedata  in  WIDTH  write data; ignored for reads
- rsp_valid  out  1  read response available
- rsp_ready  in  1  consumer accepts response
- rsp_readdata  out  WIDTH  captured read data
- master_address  out  4  Avalon address
- master_read  out  1  Avalon read strobe
- master_write  out  1  Avalon write strobe
- master_writedata  out  WIDTH  Avalon write data
- master_readdata  in  WIDTH  Avalon read data
- master_waitrequest  in  1  Avalon stall; present only with AVM_WAITREQ_EN
- busy  out  1  FIFO non-empty or FSM not in IDLE

Behaviour:
- Reset: asynchronous, active-high.
  - FIFO is emptied and the FSM goes to IDLE.
  - All outputs are 0: master_*, rsp_valid, rsp_readdata, busy. cmd_ready is 1 after reset.
  - Reset mid-transaction abandons that transaction and any queued commands; no response is produced.
- Command FIFO:
  - cmd_ready = !full, registered; there is no combinational path from the pop side.
  - Push on cmd_valid && cmd_ready.
  - Push and pop in the same cycle are legal; occupancy is then unchanged.
  - Pointers wrap modulo FIFO_DEPTH; an extra wrap bit distinguishes full from empty.
- FSM states: IDLE, BUS, RDWAIT, RESP.
  - IDLE: if the FIFO is non-empty, pop the head and register it onto master_address, master_writedata and the strobes, then go to BUS. There is a 1-cycle issue latency from push into an empty FIFO to the strobe.
  - BUS: master_write or master_read is asserted for exactly one cycle.
    - Write: if the FIFO is non-empty, pop and load the next command and stay in BUS. Back-to-back writes therefore issue one per cycle. Otherwise go to IDLE.
    - Read: go to RDWAIT with the latency counter loaded to READ_LATENCY.
  - RDWAIT: strobes are 0 and the counter decrements each cycle. In the cycle the counter reaches 1, rsp_readdata <= master_readdata and the FSM goes to RESP. Example: with READ_LATENCY=1, read is asserted in cycle t and data is captured at the end of cycle t+1.
  - RESP: rsp_valid=1 with rsp_readdata held stable until rsp_ready. On the acceptance cycle the FSM goes to IDLE and rsp_valid drops the next cycle.
    - No further bus command issues while a response is pending; only one read is ever outstanding.
    - The FIFO keeps accepting commands during RDWAIT and RESP until full.
- Bus outputs: master_read and master_write are never asserted together. master_address and master_writedata hold their last value while the strobes are 0.
- busy = (FSM != IDLE) || FIFO non-empty.

Optional Feature:
- AVM_WAITREQ_EN defined:
  - master_waitrequest port exists.
  - In BUS, while waitrequest=1, the strobes, address and data are held and no pop occurs.
  - The transaction completes on the first cycle with waitrequest=0.
  - The READ_LATENCY count starts after that cycle.
- AVM_WAITREQ_EN undefined: the port is absent and every bus cycle completes in one clock.

Test Plan:
- Reset, then push write(0x0, 0x00000001) -> master_write=1, address=0x0, writedata=0x1 for exactly 1 cycle, 2 cycles after push; busy returns to 0.
- Push write(0x0, 0xA5), write(0x4, 0x5A) on consecutive cycles -> two consecutive master_write cycles in order, no gap.
- Push read(0x8), slave returns 0x12345678 one cycle after read -> rsp_valid=1, rsp_readdata=0x12345678. With rsp_ready held 0 for 5 cycles, the data stays stable and there is no new bus activity.
- Push 6 commands while a read response is stalled -> cmd_ready drops after 4 are queued. Releasing rsp_ready drains the FIFO in order with no loss or duplication.
- Assert reset in RDWAIT with 3 commands queued -> all outputs 0 immediately, no response emitted, no queued command issued after reset release.
- With AVM_WAITREQ_EN, hold waitrequest=1 for 3 cycles on write(0x4, 0x7) -> strobe, address and data held 4 cycles total; the next command is not popped early.
